move_scheduler: RTL
===================

MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 Parameter: TICK_DIV, default 1666667, clk cycles per movement tick (60 Hz at 100 MHz); legal range 2..2^24-1.
REQ-002 clk  in  1  system clock; all logic on rising edge; single clock domain.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 A_signal  in  1  player key, maps to horizontal-plus.
REQ-005 D_signal  in  1  player key, maps to horizontal-minus.
REQ-006 W_signal  in  1  player key, maps to vertical-plus.
REQ-007 S_signal  in  1  player key, maps to vertical-minus.
REQ-008 SPACE_signal  in  1  pause key, level input.
REQ-009 upd_ready  in  1  position datapath accepts the current update request.
REQ-010 upd_valid  out  1  update request pending.
REQ-011 upd_id  out  1  entity: 0 = CY (player), 1 = monster_1.
REQ-012 upd_dir  out  2  0 = H+, 1 = H-, 2 = V+, 3 = V-.
REQ-013 upd_move  out  1  1 = apply one-pixel step; 0 = hold position (bounds checks only).
REQ-014 round_done  out  1  one-cycle pulse after both entities are updated.
REQ-015 paused  out  1  pause state.
REQ-016 overrun  out  1  sticky: a tick arrived while a round was in progress.
REQ-017 miss_cnt  out  8  count of overrun ticks, saturating at 255.

Function
REQ-018 The tick counter shall count 0..TICK_DIV-1, free-running regardless of pause, and raise an internal tick for one cycle when it wraps from TICK_DIV-1 to 0; the first tick occurs TICK_DIV cycles after rst deasserts.
REQ-019 The FSM shall have states IDLE, PLAYER and MONSTER.
REQ-020 IDLE -> PLAYER shall occur on tick when paused = 0; in the same cycle, keys are snapshotted into a registered direction/move pair.
REQ-021 Key priority for the snapshot shall be A > D > W > S: the highest asserted key sets upd_dir and upd_move = 1; with no key asserted, upd_move = 0 and upd_dir = 0.
REQ-022 In PLAYER, outputs shall be upd_valid = 1, upd_id = 0, with the snapshot dir/move; key changes during a round shall not alter the request.
REQ-023 In MONSTER, outputs shall be upd_valid = 1, upd_id = 1, upd_dir = H+, upd_move = 1.
REQ-024 Handshake: a request is accepted in a cycle with upd_valid & upd_ready; upd_id, upd_dir and upd_move shall be held stable while upd_valid = 1 and not accepted.
REQ-025 Accept in PLAYER -> MONSTER; accept in MONSTER -> IDLE, and round_done = 1 in the following cycle only.
REQ-026 With upd_ready held at 1, upd_valid shall be high for exactly 2 cycles, starting the cycle after the tick.
REQ-027 In IDLE, upd_valid shall be 0 and upd_id, upd_dir and upd_move shall be 0.
REQ-028 A tick while the FSM is in PLAYER or MONSTER shall set overrun = 1 and increment miss_cnt (saturating at 255); the round shall continue, and no second round shall be queued.
REQ-029 A tick in IDLE while paused = 1 shall be ignored: no round, no overrun.
REQ-030 Each rising edge of SPACE_signal (registered previous value) shall toggle paused; a round already in progress shall complete normally.
REQ-031 When a SPACE rising edge and a tick occur in the same cycle in IDLE, the tick shall use the pre-toggle paused value.

Reset
REQ-032 While rst = 1 at a clock edge, the following shall be cleared: FSM to IDLE, tick counter to 0, SPACE history to 0, paused = 0, overrun = 0, miss_cnt = 0, round_done = 0, and all upd_* outputs to 0.
REQ-033 Reset mid-round shall abandon the request: upd_valid = 0 from the edge at which rst is sampled, with no round_done pulse.

Structure
REQ-034 A shared package move_sched_pkg shall hold the state enum, the upd_dir codes, the entity ID constants and the TICK_DIV default.
REQ-035 The tick counter shall be one sub-module, tick_divider (parameter TICK_DIV, ports clk, rst, tick).
REQ-036 All outputs shall be registered.

Verification (TICK_DIV = 4 on the bench)
REQ-037 rst released, upd_ready = 1, W held -> tick at cycle 4; upd_valid high cycles 5-6, id 0 dir 2 move 1, then id 1 dir 0 move 1; round_done high cycle 7.
REQ-038 A and S both held, upd_ready = 0 for 3 cycles then 1 -> player request id 0 dir 0 held stable for 4 cycles; keys changed mid-round to D -> request unchanged.
REQ-039 upd_ready = 0 for 10 cycles -> overrun = 1, miss_cnt = 2; after ready, the round completes and the next tick starts a fresh round.
REQ-040 SPACE pulse -> paused = 1, no upd_valid across 3 ticks, miss_cnt stays 0; second SPACE pulse -> rounds resume at the next tick.
REQ-041 rst asserted while upd_valid = 1 in MONSTER -> upd_valid = 0 the next cycle, no round_done, counters 0; miss_cnt forced to 255 via stalls stays at 255 on further overruns.

Source files
------------

// File: rtl/move_sched_pkg.sv
// move_sched_pkg: shared constants for the movement scheduler.
// FSM states, direction codes, entity IDs, key priority helper.
package move_sched_pkg;

  localparam int unsigned TICK_DIV_DEF = 1666667;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PLAYER  = 2'd1;
  localparam logic [1:0] S_MONSTER = 2'd2;

  localparam logic [1:0] DIR_HP = 2'd0;
  localparam logic [1:0] DIR_HM = 2'd1;
  localparam logic [1:0] DIR_VP = 2'd2;
  localparam logic [1:0] DIR_VM = 2'd3;

  localparam logic ID_CY  = 1'b0;
  localparam logic ID_MON = 1'b1;

  // Returns {move, dir}; A > D > W > S.
  function automatic logic [2:0] key_snap(
    input logic a,
    input logic d,
    input logic w,
    input logic s
  );
    logic [2:0] r;
    priority case (1'b1)
      a:       r = {1'b1, DIR_HP};
      d:       r = {1'b1, DIR_HM};
      w:       r = {1'b1, DIR_VP};
      s:       r = {1'b1, DIR_VM};
      default: r = {1'b0, DIR_HP};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/move_scheduler_if.sv
// move_scheduler_if: update request handshake to the
// position datapath.
interface move_scheduler_if;
  logic       upd_valid;
  logic       upd_ready;
  logic       upd_id;
  logic [1:0] upd_dir;
  logic       upd_move;

  modport master (
    output upd_valid,
    output upd_id,
    output upd_dir,
    output upd_move,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  upd_id,
    input  upd_dir,
    input  upd_move,
    output upd_ready
  );
endinterface

// File: rtl/tick_divider.sv
// tick_divider: free-running 0..TICK_DIV-1 counter with a
// registered one-cycle tick on wrap.
module tick_divider
  import move_sched_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [23:0] LAST = 24'(TICK_DIV - 1);

  logic [23:0] cnt;
  logic        wrap;

  assign wrap = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= wrap;
      cnt  <= wrap ? '0 : cnt + 24'd1;
    end
  end

endmodule

// File: rtl/move_scheduler.sv
// move_scheduler: per-tick round that updates the player, then
// monster_1, with pause and overrun tracking.
module move_scheduler
  import move_sched_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    A_signal,
  input  logic                    D_signal,
  input  logic                    W_signal,
  input  logic                    S_signal,
  input  logic                    SPACE_signal,
  move_scheduler_if.master        upd,
  output logic                    round_done,
  output logic                    paused,
  output logic                    overrun,
  output logic [7:0]              miss_cnt
);

  logic       tick;
  logic [1:0] state;
  logic       space_q;
  logic       accept;
  logic [2:0] snap;

  assign accept = upd.upd_valid & upd.upd_ready;
  assign snap   = key_snap(A_signal, D_signal,
                           W_signal, S_signal);

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      upd.upd_valid <= 1'b0;
      upd.upd_id    <= ID_CY;
      upd.upd_dir   <= DIR_HP;
      upd.upd_move  <= 1'b0;
      round_done    <= 1'b0;
    end else begin
      round_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (tick && !paused) begin
            state         <= S_PLAYER;
            upd.upd_valid <= 1'b1;
            upd.upd_id    <= ID_CY;
            upd.upd_dir   <= snap[1:0];
            upd.upd_move  <= snap[2];
          end
        end
        S_PLAYER: begin
          if (accept) begin
            state        <= S_MONSTER;
            upd.upd_id   <= ID_MON;
            upd.upd_dir  <= DIR_HP;
            upd.upd_move <= 1'b1;
          end
        end
        S_MONSTER: begin
          if (accept) begin
            state         <= S_IDLE;
            upd.upd_valid <= 1'b0;
            upd.upd_id    <= ID_CY;
            upd.upd_dir   <= DIR_HP;
            upd.upd_move  <= 1'b0;
            round_done    <= 1'b1;
          end
        end
        default: begin
          state         <= S_IDLE;
          upd.upd_valid <= 1'b0;
          upd.upd_id    <= ID_CY;
          upd.upd_dir   <= DIR_HP;
          upd.upd_move  <= 1'b0;
        end
      endcase
    end
  end

  // paused is read pre-toggle by the IDLE branch above
  always_ff @(posedge clk) begin
    if (rst) begin
      space_q  <= 1'b0;
      paused   <= 1'b0;
      overrun  <= 1'b0;
      miss_cnt <= '0;
    end else begin
      space_q <= SPACE_signal;
      if (SPACE_signal && !space_q)
        paused <= ~paused;
      if (tick && state != S_IDLE) begin
        overrun <= 1'b1;
        if (miss_cnt != 8'hFF)
          miss_cnt <= miss_cnt + 8'd1;
      end
    end
  end

endmodule
